pled_color_sequencer: RTL and testbench
=======================================

Name: pled_color_sequencer

Overview:
- Stimulus-side counterpart to the on-chip logic-analyzer probe set on the Pmod PowerLED board.
- Produces the `color`, `led` and `counter` signals that the probe set samples.
- Gated by PLL lock, cycles the RGB colour code, fading each colour up and down with a PWM-driven `led` output.
- Sits between the PLL (`pll_lock`) and the Pmod_PLED2 pin drivers.

Parameters:
- PWM_BITS, 8, PWM counter/duty width; period = 2^PWM_BITS clocks.
- STEP_DIV, 1000, clocks per duty increment/decrement (≥2).
- HOLD_STEPS, 256, STEP_DIV ticks spent at full duty.

Ports:
- sys_clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- pll_lock  input  1  PLL locked; may be asynchronous; 2-flop synchronised internally.
- enable  input  1  run/pause; low freezes sequence and PWM counter, `led` forced 0.
- color  output  3  current colour code {R,G,B}.
- led  output  1  registered PWM output.
- counter  output  3  completed full colour cycles, modulo 8.
- busy  output  1  high in any state except WAIT_LOCK.

Behaviour:
- Reset (reset=0, asynchronous): state=WAIT_LOCK, color=3'd1, led=0, counter=0, duty=0, pwm_cnt=0, step_cnt=0, hold_cnt=0, busy=0.
- tick: one-cycle pulse when step_cnt reaches STEP_DIV-1; step_cnt then wraps to 0. step_cnt counts only when enable=1 and state≠WAIT_LOCK.
- PWM: pwm_cnt free-runs 0..2^PWM_BITS-1 while enable=1. led <= (pwm_cnt < duty) && enable && state≠WAIT_LOCK. One-cycle latency.
  - duty=0 → led constantly 0.
  - duty=max → led high 255 of 256 clocks.
- States:
  - WAIT_LOCK: duty=0. On synchronised lock=1 → RAMP_UP (step_cnt cleared).
  - RAMP_UP: each tick duty+1. On the tick where duty==max → HOLD, hold_cnt=0.
  - HOLD: each tick hold_cnt+1. On the tick where hold_cnt==HOLD_STEPS-1 → RAMP_DOWN.
  - RAMP_DOWN: each tick duty-1. On the tick where duty==1 (reaching 0) → NEXT.
  - NEXT (one cycle): color <= color+1, with 7→1 wrap (0 skipped, see Optional Feature). On the 7→1 wrap, counter <= counter+1, with 7→0 wrap. Then → RAMP_UP.
- Duty arithmetic saturates; it never wraps below 0 or above max.
- Lock loss: synchronised lock=0 in any state → WAIT_LOCK next cycle.
  - duty=0, led=0 within 1 cycle.
  - color and counter retain their values.
  - Resumes at RAMP_UP with the same colour.
- enable=0: all state held, including tick generation; led=0. Resumes exactly where paused. Lock loss still takes priority.
- Reset asserted mid-ramp: immediate return to reset values; no glitch beyond the asynchronous clear.
- Simultaneous lock loss and NEXT: lock loss wins; colour is not advanced.

Optional Feature:
- Macro: PLED_BLACK_STEP_EN.
- Defined: colour sequence includes 0 (0→1→…→7→0). The cycle wrap is 7→0, and counter increments on that wrap. Reset colour = 0. While color==0, led is still PWM'd (the board shows off).
- Undefined: 0 is skipped as specified above.

Decomposition:
- Package pled_pkg:
  - state enum (WAIT_LOCK, RAMP_UP, HOLD, RAMP_DOWN, NEXT);
  - COLOR_FIRST / COLOR_LAST constants selected by PLED_BLACK_STEP_EN;
  - default PWM_BITS.
- Sub-module pled_pwm: pwm_cnt plus comparator plus enable gating, output registered. Reused by later multi-channel LED blocks.

Test Plan:
- Lock bring-up: STEP_DIV=4, HOLD_STEPS=2, PWM_BITS=3, pll_lock rises after reset.
  - busy high 3 cycles later (2-flop sync plus state register).
  - duty reaches 7 after 7 ticks (28 clocks).
- PWM duty check: force duty=3 in HOLD (PWM_BITS=3) → led high exactly 3 of every 8 clocks. At duty=7, high 7 of 8.
- Full cycle: run 7 colours → color sequence 1,2,…,7,1 and counter 0→1 on the wrap.
  - With PLED_BLACK_STEP_EN: sequence 0..7,0, counter increments on 7→0.
- Lock loss mid-RAMP_UP at duty=4, color=3 → led=0 next cycle, busy=0, color stays 3. Relock → ramp restarts from duty 0, color 3.
- enable low for 50 cycles in HOLD → led=0, hold_cnt and pwm_cnt frozen. After release, HOLD completes with the original remaining tick count.
- Asynchronous reset pulse mid-RAMP_DOWN, not aligned to a sys_clk edge → outputs reach reset values immediately: color=1, counter=0, led=0.

Source files
------------

// File: rtl/pled_color_sequencer_pkg.sv
// Shared state encoding, colour range and defaults for the PowerLED stimulus sequencer.
// No logic: constants only; PLED_BLACK_STEP_EN selects whether black (0) joins the colour cycle.
package pled_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        NEXT
    } state_t;

    localparam int PWM_BITS_DEFAULT = 8;

`ifdef PLED_BLACK_STEP_EN
    localparam logic [2:0] COLOR_FIRST = 3'd0;
`else
    localparam logic [2:0] COLOR_FIRST = 3'd1;
`endif
    localparam logic [2:0] COLOR_LAST = 3'd7;

    function automatic logic [2:0] next_color(input logic [2:0] c);
        return (c == COLOR_LAST) ? COLOR_FIRST : c + 3'd1;
    endfunction

endpackage

// File: rtl/pled_color_sequencer_if.sv
// Control inputs and colour/PWM/status outputs of the PowerLED sequencer.
// Master is the sequencer; slave is the pin-driver / probe side that supplies lock and enable.
interface pled_color_sequencer_if;
    logic       pll_lock;
    logic       enable;
    logic [2:0] color;
    logic       led;
    logic [2:0] counter;
    logic       busy;

    modport master (input pll_lock, enable, output color, led, counter, busy);
    modport slave  (output pll_lock, enable, input color, led, counter, busy);
endinterface

// File: rtl/pled_color_sequencer_pwm.sv
// Single-channel PWM: free-running counter compared against duty, output registered (1 cycle).
// No backpressure: cnt_en freezes the counter, out_en forces the output low.
module pled_pwm
    import pled_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cnt_en,
    input  logic                out_en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led     <= 1'b0;
        end else begin
            if (cnt_en) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            led <= out_en && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/pled_color_sequencer.sv
// Lock-gated RGB colour stepper fading each colour up/hold/down via PWM; led lags duty by 1 cycle.
// enable=0 freezes everything (led=0), lock loss always wins; PLED_BLACK_STEP_EN adds colour 0.
module pled_color_sequencer
    import pled_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter int STEP_DIV   = 1000,
    parameter int HOLD_STEPS = 256
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    pled_color_sequencer_if.master  bus
);

    localparam int SW = $clog2(STEP_DIV);
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic                lock_s1, lock_s2;
    state_t              state;
    logic [PWM_BITS-1:0] duty;
    logic [SW-1:0]       step_cnt;
    logic [HW-1:0]       hold_cnt;
    logic [2:0]          color_q, counter_q;
    logic                busy_q;
    logic                run, tick, led_q;

    assign run  = bus.enable && (state != WAIT_LOCK);
    assign tick = run && (step_cnt == SW'(STEP_DIV - 1));

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= bus.pll_lock;
            lock_s2 <= lock_s1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_LOCK;
            duty      <= '0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
            color_q   <= COLOR_FIRST;
            counter_q <= 3'd0;
            busy_q    <= 1'b0;
        end else if (!lock_s2) begin
            // Lock loss outranks enable and NEXT; colour and counter are kept.
            state    <= WAIT_LOCK;
            duty     <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
            busy_q   <= 1'b0;
        end else if (state == WAIT_LOCK) begin
            state    <= RAMP_UP;
            step_cnt <= '0;
            busy_q   <= 1'b1;
        end else if (bus.enable) begin
            step_cnt <= tick ? '0 : step_cnt + 1'b1;
            case (state)
                RAMP_UP: if (tick) begin
                    if (duty == DUTY_MAX) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        duty <= duty + 1'b1;
                    end
                end
                HOLD: if (tick) begin
                    if (hold_cnt == HW'(HOLD_STEPS - 1)) begin
                        state <= RAMP_DOWN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RAMP_DOWN: if (tick) begin
                    if (duty != '0) begin
                        duty <= duty - 1'b1;
                    end
                    if (duty <= PWM_BITS'(1)) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    color_q <= next_color(color_q);
                    if (color_q == COLOR_LAST) begin
                        counter_q <= counter_q + 3'd1;
                    end
                    state <= RAMP_UP;
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    // Lock term drops led on the same edge the FSM leaves its active states.
    pled_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk    (sys_clk),
        .rst_n  (reset),
        .cnt_en (bus.enable),
        .out_en (run && lock_s2),
        .duty   (duty),
        .led    (led_q)
    );

    assign bus.color   = color_q;
    assign bus.led     = led_q;
    assign bus.counter = counter_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_pled_color_sequencer.sv
// Bench for pled_color_sequencer: tick-count reference model compared every cycle, plus literal checks.
// Small parameters (PWM_BITS=3, STEP_DIV=4, HOLD_STEPS=2) keep full colour cycles short.
module tb_pled_color_sequencer;

    localparam int B    = 3;
    localparam int DIV  = 4;
    localparam int H    = 2;
    localparam int MAXD = (1 << B) - 1;
    localparam int T    = 2 * MAXD + 1 + H;  // ticks spent per colour before NEXT
`ifdef PLED_BLACK_STEP_EN
    localparam logic [2:0] CF = 3'd0;
`else
    localparam logic [2:0] CF = 3'd1;
`endif

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    pled_color_sequencer_if bus ();

    pled_color_sequencer #(.PWM_BITS(B), .STEP_DIV(DIV), .HOLD_STEPS(H)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: position within a colour is just the number of ticks consumed.
    bit         m_s1, m_s2, m_locked, m_next, m_led, m_lk;
    int         m_t, m_step, m_pwm, m_d;
    logic [2:0] m_color   = CF;
    logic [2:0] m_counter = 3'd0;

    function automatic int duty_of(input int t);
        if (t <= MAXD)         return t;
        if (t <= MAXD + 1 + H) return MAXD;
        return MAXD - (t - (MAXD + 1 + H));
    endfunction

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_locked = 0; m_next = 0; m_led = 0;
            m_t = 0; m_step = 0; m_pwm = 0;
            m_color = CF; m_counter = 3'd0;
        end else begin
            m_d   = duty_of(m_t);
            m_lk  = m_s2;
            m_led = m_lk && m_locked && bus.enable && (m_pwm < m_d);
            if (bus.enable) m_pwm = (m_pwm + 1) % (1 << B);
            m_s2 = m_s1;
            m_s1 = bus.pll_lock;
            if (!m_lk) begin
                m_locked = 0; m_t = 0; m_next = 0; m_step = 0;
            end else if (!m_locked) begin
                m_locked = 1; m_t = 0; m_step = 0;
            end else if (bus.enable) begin
                if (m_next) begin
                    if (m_color == 3'd7) begin
                        m_color   = CF;
                        m_counter = m_counter + 3'd1;
                    end else begin
                        m_color = m_color + 3'd1;
                    end
                    m_next = 0;
                    m_t    = 0;
                end else if (m_step == DIV - 1) begin
                    m_t = m_t + 1;
                    if (m_t == T) m_next = 1;
                end
                m_step = (m_step + 1) % DIV;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_on) begin
            n_tests++;
            if (bus.color !== m_color || bus.led !== m_led ||
                bus.counter !== m_counter || bus.busy !== m_locked) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got color=%0d led=%0b counter=%0d busy=%0b expected color=%0d led=%0b counter=%0d busy=%0b",
                         $time, bus.color, bus.led, bus.counter, bus.busy,
                         m_color, m_led, m_counter, m_locked);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit cond_hit(input int kind);
        case (kind)
            0: return m_locked && !m_next && m_t == MAXD + 1;
            1: return m_locked && !m_next && m_color == 3'd3 && m_t == 4;
            2: return m_locked && !m_next && m_t == T - 1 && m_step == DIV - 2;
            3: return m_locked && !m_next && m_t == MAXD + 1 && m_step == 1;
            4: return m_locked && !m_next && m_t == MAXD + 1 + H + 2;
            default: return 0;
        endcase
    endfunction

    task automatic wait_cond(input int kind, input int budget, input string name);
        int i;
        for (i = 0; i < budget && !cond_hit(kind); i++) @(negedge sys_clk);
        n_tests++;
        if (!cond_hit(kind)) begin
            n_fail++;
            $display("FAIL timeout_%s waited %0d cycles expected condition within %0d", name, i, budget);
        end
    endtask

    task automatic wait_color_change(input logic [2:0] prev, input int budget,
                                     input string name, output int cycles);
        cycles = 0;
        while (bus.color === prev && cycles < budget) begin
            @(negedge sys_clk);
            cycles++;
        end
        if (bus.color === prev) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s colour stuck at %0d for %0d cycles", name, prev, budget);
        end
    endtask

    initial begin
        int cnt, cyc;
        logic [2:0] c, col_before;
        bit any_led;

        bus.pll_lock = 1'b0;
        bus.enable   = 1'b1;
        #2 reset = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk_on = 1'b1;
        check("reset_color", bus.color, CF);
        check("reset_led", bus.led, 0);
        check("reset_counter", bus.counter, 0);
        check("reset_busy", bus.busy, 0);
        reset = 1'b1;

        // Lock bring-up: 2-flop sync plus state register
        @(negedge sys_clk);
        bus.pll_lock = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("busy_before_3cyc", bus.busy, 0);
        @(negedge sys_clk);
        check("busy_after_3cyc", bus.busy, 1);

        // Full duty: 7 highs in 8 consecutive clocks
        wait_cond(0, 200, "hold_entry");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            cnt += int'(bus.led);
        end
        check("duty_max_highs_of_8", cnt, 7);

        // Full colour cycle
        c = CF;
        for (int k = 0; k < 8; k++) begin
            if (k == 7 && CF == 3'd1) break;
            check("counter_before_wrap", bus.counter, 0);
            wait_color_change(c, 200, "color_step", cyc);
            c = (c == 3'd7) ? CF : c + 3'd1;
            check("color_seq", bus.color, c);
        end
        check("counter_after_wrap", bus.counter, 1);

        // Lock loss mid ramp-up at duty 4, colour 3
        wait_cond(1, 400, "ramp_duty4_color3");
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("lockloss_busy", bus.busy, 0);
        check("lockloss_led", bus.led, 0);
        check("lockloss_color", bus.color, 3);
        bus.pll_lock = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("relock_busy", bus.busy, 1);
        check("relock_color", bus.color, 3);

        // Lock loss landing on NEXT: colour must not advance
        wait_cond(2, 300, "pre_next");
        col_before = bus.color;
        bus.pll_lock = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("next_vs_lockloss_color", bus.color, col_before);
        check("next_vs_lockloss_busy", bus.busy, 0);
        bus.pll_lock = 1'b1;

        // Pause in HOLD for 50 cycles, then HOLD/ramp-down resume exactly
        wait_cond(3, 300, "hold_pause_point");
        col_before = bus.color;
        bus.enable = 1'b0;
        any_led = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            any_led |= bus.led;
        end
        check("pause_led_low", any_led, 0);
        check("pause_busy", bus.busy, 1);
        check("pause_color_held", bus.color, col_before);
        bus.enable = 1'b1;
        wait_color_change(col_before, 100, "resume", cyc);
        check("resume_cycles_to_next", cyc, 36);

        // Asynchronous reset mid ramp-down, off the clock edge
        wait_cond(4, 300, "ramp_down");
        @(posedge sys_clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_color", bus.color, CF);
        check("async_rst_counter", bus.counter, 0);
        check("async_rst_led", bus.led, 0);
        check("async_rst_busy", bus.busy, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b1;

        // Random enable/lock activity
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            bus.enable = ($urandom_range(0, 15) != 0);
            if (bus.pll_lock && $urandom_range(0, 299) == 0)
                bus.pll_lock = 1'b0;
            else if (!bus.pll_lock && $urandom_range(0, 19) == 0)
                bus.pll_lock = 1'b1;
        end

        // Long steady run so counter wraps modulo 8
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        repeat (4500) @(negedge sys_clk);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
